// File: rtl/systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl
//   Job sequencer for a PE_ROW_NUM x PE_COL_NUM systolic array. For one
//   output tile it reads K operand pairs from the buffers and generates skewed
//   lane enables for i_in/w_in. It then waits for the wavefront to drain and
//   pulses shift_out once. Finally it marks res_out lanes valid while the
//   results shift out, and pulses done.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high (overrides everything)
//   start      in   job request, only looked at in IDLE
//   k_len      in   accumulation depth, latched when a job is accepted
//   abort      in   synchronous job kill
//   busy       out  job in progress
//   done       out  one-cycle pulse when the tile results are delivered
//   rd_en      out  operand buffer read enable (i and w buffers)
//   rd_addr    out  operand buffer read address
//   row_en     out  per-row i_in lane enable
//   col_en     out  per-column w_in lane enable
//   shift_out  out  drives the array shift_in
//   res_valid  out  per-row res_out lane valid
//   state_dbg  out  current FSM state encoding, for observation only
//
// Handshake: start acts as a request and the IDLE state acts as ready. A job
// is accepted in an IDLE cycle with start high, k_len != 0 and abort low.
// In any other cycle, start is ignored and no request is queued.
// ---------------------------------------------------------------------------
module systolic_seq_ctrl #(
  parameter int PE_ROW_NUM = 4,
  parameter int PE_COL_NUM = 4,
  parameter int K_WIDTH    = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [K_WIDTH-1:0]    k_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [PE_ROW_NUM-1:0] row_en,
  output logic [PE_COL_NUM-1:0] col_en,
  output logic                  shift_out,
  output logic [PE_ROW_NUM-1:0] res_valid,
  output logic [2:0]            state_dbg
);

  // Wavefront drain length and counter sizing.
  localparam int DRAIN_LEN = PE_ROW_NUM + PE_COL_NUM;
  localparam int RC_W      = $clog2(DRAIN_LEN + 1);
  localparam int CNT_W     = (K_WIDTH > RC_W) ? K_WIDTH : RC_W;
  localparam int DL_LEN    = (PE_ROW_NUM > PE_COL_NUM) ? PE_ROW_NUM : PE_COL_NUM;

  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_LEN - 1);
  localparam logic [CNT_W-1:0] COLLECT_LAST = CNT_W'(DRAIN_LEN - 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FEED    = 3'd1,
    DRAIN   = 3'd2,
    SHIFT   = 3'd3,
    COLLECT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [K_WIDTH-1:0]  k_q, k_d;
  logic [DL_LEN-1:0]   dl_q, dl_d;
  logic [CNT_W-1:0]    k_last;

  // The delay line holds rd_en delayed by 1..DL_LEN cycles. Bit n is rd_en
  // delayed by n+1 cycles, which matches the one-cycle buffer read latency
  // plus one cycle of skew per lane.
  assign row_en    = dl_q[PE_ROW_NUM-1:0];
  assign col_en    = dl_q[PE_COL_NUM-1:0];
  assign state_dbg = state_q;
  assign k_last    = CNT_W'(k_q) - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      dl_q    <= dl_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    shift_out = 1'b0;
    res_valid = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && (k_len != '0)) begin
          state_d = FEED;
          k_d     = k_len;
        end
      end

      // One buffer read per cycle, addresses 0..K-1.
      FEED: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = ADDR_WIDTH'(cnt_q);
        if (cnt_q == k_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Give the last operand time to reach the far corner PE.
      DRAIN: begin
        busy = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHIFT: begin
        busy      = 1'b1;
        shift_out = 1'b1;
        state_d   = COLLECT;
        cnt_d     = '0;
      end

      // shift_in reaches row r r cycles later. Each row then carries
      // PE_COL_NUM results, one per cycle.
      COLLECT: begin
        busy = 1'b1;
        for (int r = 0; r < PE_ROW_NUM; r++) begin
          res_valid[r] = (cnt_q >= CNT_W'(r)) && (cnt_q < CNT_W'(r + PE_COL_NUM));
        end
        if (cnt_q == COLLECT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // abort kills the job (and blocks an accept in IDLE).
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    dl_d = abort ? '0 : ((dl_q << 1) | DL_LEN'(rd_en));
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_seq_ctrl
//   Directed bench for systolic_seq_ctrl (4x4 array, K_WIDTH=8). A job-level
//   model tracks the active job's accept cycle and depth. It derives every
//   output from the timing rules. One negedge process compares the DUT with
//   the model every cycle and also checks hand-computed literal windows for
//   each scenario.
// ---------------------------------------------------------------------------
module tb_systolic_seq_ctrl;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int KW = 8;
  localparam int AW = 8;
  localparam int D  = R + C;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [R-1:0]  row_en;
  logic [C-1:0]  col_en;
  logic          shift_out;
  logic [R-1:0]  res_valid;
  logic [2:0]    state_dbg;

  systolic_seq_ctrl #(
    .PE_ROW_NUM (R),
    .PE_COL_NUM (C),
    .K_WIDTH    (KW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .row_en    (row_en),
    .col_en    (col_en),
    .shift_out (shift_out),
    .res_valid (res_valid),
    .state_dbg (state_dbg)
  );

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  // Scenario anchors, written by the driver only.
  int t1_t0  = -1000;
  int t3_t0  = -1000;
  int t4_t0  = -1000;
  int t4b_t0 = -1000;
  int t5_t0  = -1000;
  int t6_t0  = -1000;

  // Job model: one job at a time, identified by accept cycle and depth.
  bit m_active = 1'b0;
  int m_t0     = 0;
  int m_k      = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (abort || (cyc == m_t0 + m_k + D + 1 + R + C)) m_active = 1'b0;
    end else if (start && (k_len != '0) && !abort) begin
      m_active = 1'b1;
      m_t0     = cyc;
      m_k      = int'(k_len);
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int c, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
    end
  endtask

  function automatic bit inw(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // scoreboard / compare process
  logic          e_busy, e_done, e_rd, e_sh;
  logic [AW-1:0] e_addr;
  logic [R-1:0]  e_row, e_res;
  logic [C-1:0]  e_col;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      int c;
      int d;
      int s;
      c = cyc;
      d = c - m_t0;
      s = m_k + D + 1;  // shift cycle, relative to accept
      e_busy = m_active && inw(d, 1, s + R + C);
      e_done = m_active && (d == s + R + C);
      e_rd   = m_active && inw(d, 1, m_k);
      e_sh   = m_active && (d == s);
      e_addr = AW'(d - 1);
      for (int r = 0; r < R; r++) e_row[r] = m_active && inw(d, 2 + r, 1 + r + m_k);
      for (int k = 0; k < C; k++) e_col[k] = m_active && inw(d, 2 + k, 1 + k + m_k);
      for (int r = 0; r < R; r++) e_res[r] = m_active && inw(d, s + 1 + r, s + r + C);

      chk("busy", c, 32'(busy), 32'(e_busy));
      chk("done", c, 32'(done), 32'(e_done));
      chk("rd_en", c, 32'(rd_en), 32'(e_rd));
      if (e_rd) chk("rd_addr", c, 32'(rd_addr), 32'(e_addr));
      chk("row_en", c, 32'(row_en), 32'(e_row));
      chk("col_en", c, 32'(col_en), 32'(e_col));
      chk("shift_out", c, 32'(shift_out), 32'(e_sh));
      chk("res_valid", c, 32'(res_valid), 32'(e_res));

      // Nominal K=3, T0=10: hand-derived cycle windows.
      if (inw(c, 10, 31)) begin
        chk("t2_busy", c, 32'(busy), 32'(inw(c, 11, 30)));
        chk("t2_rd_en", c, 32'(rd_en), 32'(inw(c, 11, 13)));
        if (c == 11) chk("t2_addr11", c, 32'(rd_addr), 32'd0);
        if (c == 12) chk("t2_addr12", c, 32'(rd_addr), 32'd1);
        if (c == 13) chk("t2_addr13", c, 32'(rd_addr), 32'd2);
        chk("t2_row0", c, 32'(row_en[0]), 32'(inw(c, 12, 14)));
        chk("t2_row3", c, 32'(row_en[3]), 32'(inw(c, 15, 17)));
        chk("t2_col0", c, 32'(col_en[0]), 32'(inw(c, 12, 14)));
        chk("t2_col3", c, 32'(col_en[3]), 32'(inw(c, 15, 17)));
        chk("t2_shift", c, 32'(shift_out), 32'(c == 22));
        chk("t2_res0", c, 32'(res_valid[0]), 32'(inw(c, 23, 26)));
        chk("t2_res3", c, 32'(res_valid[3]), 32'(inw(c, 26, 29)));
        chk("t2_done", c, 32'(done), 32'(c == 30));
      end

      // start with k_len = 0 never starts a job.
      if (inw(c, t3_t0 + 1, t3_t0 + 6)) begin
        chk("t3_busy", c, 32'(busy), 32'd0);
        chk("t3_rd_en", c, 32'(rd_en), 32'd0);
        chk("t3_done", c, 32'(done), 32'd0);
      end

      // Abort sampled at the end of T0+5 (DRAIN).
      if (c == t4_t0 + 6)
        chk("t4_clear", c,
            32'({busy, done, rd_en, row_en, col_en, shift_out, res_valid}), 32'd0);
      if (inw(c, t4_t0 + 6, t4_t0 + 25)) begin
        chk("t4_no_shift", c, 32'(shift_out), 32'd0);
        chk("t4_no_done", c, 32'(done), 32'd0);
      end
      if (inw(c, t4b_t0 + 1, t4b_t0 + 21))
        chk("t4b_done", c, 32'(done), 32'(c == t4b_t0 + 20));

      // Back-to-back K=1 with start held high.
      if (inw(c, t5_t0 + 1, t5_t0 + 38)) begin
        chk("t5_done", c, 32'(done), 32'((c == t5_t0 + 18) || (c == t5_t0 + 37)));
        chk("t5_rd_en", c, 32'(rd_en), 32'((c == t5_t0 + 1) || (c == t5_t0 + 20)));
        chk("t5_overlap", c, 32'(rd_en && (res_valid != '0)), 32'd0);
      end

      // Maximum depth K=255.
      if (inw(c, t6_t0 + 1, t6_t0 + 273)) begin
        chk("t6_rd_en", c, 32'(rd_en), 32'(c <= t6_t0 + 255));
        if (c <= t6_t0 + 255) chk("t6_addr", c, 32'(rd_addr), 32'(c - t6_t0 - 1));
        chk("t6_done", c, 32'(done), 32'(c == t6_t0 + 272));
      end

      // Reset held three cycles in the middle of FEED.
      if (inw(c, t1_t0 + 4, t1_t0 + 8)) begin
        chk("t1_busy", c, 32'(busy), 32'd0);
        chk("t1_rd_en", c, 32'(rd_en), 32'd0);
        chk("t1_row_en", c, 32'(row_en), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [KW-1:0] k);
    start = 1'b1;
    k_len = k;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    k_len = '0;
    repeat (3) step();
    rst = 1'b0;
    while (cyc < 10) step();

    // Nominal job, T0 = 10
    pulse_start(8'd3);
    repeat (25) step();

    // start with k_len = 0
    t3_t0 = cyc;
    start = 1'b1;
    k_len = 8'd0;
    repeat (4) step();
    start = 1'b0;
    repeat (4) step();

    // abort in DRAIN, then a fresh nominal job
    t4_t0 = cyc;
    pulse_start(8'd3);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (22) step();
    t4b_t0 = cyc;
    pulse_start(8'd3);
    repeat (25) step();

    // back-to-back, start held through two jobs
    t5_t0 = cyc;
    start = 1'b1;
    k_len = 8'd1;
    repeat (38) step();
    start = 1'b0;
    repeat (5) step();

    // maximum depth
    t6_t0 = cyc;
    pulse_start(8'd255);
    repeat (280) step();

    // reset mid-FEED
    t1_t0 = cyc;
    pulse_start(8'd5);
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (6) step();

    // final report
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
